// File: rtl/int_ctrl.sv
// Programmable interrupt controller: edge/level latching, masking and single-bit
// priority nesting of up to six sources, presented to CP0 as hwint[5:0].
module int_ctrl #(
    parameter int N_SRC = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sel,
    input  logic [1:0]       addr,
    input  logic [3:0]       byteen,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    input  logic [N_SRC-1:0] irq_in,
    output logic [5:0]       hwint,
    output logic [N_SRC-1:0] irq_ack
);

    typedef enum logic [1:0] {
        REG_PEND = 2'd0,
        REG_MASK = 2'd1,
        REG_MODE = 2'd2,
        REG_CTRL = 2'd3
    } reg_e;

    logic [N_SRC-1:0] r_irq_q, r_pend, r_mask, r_mode, r_isr, r_ack;

    logic             w_top_any, w_valid, w_wr0, w_claim, w_eoi, w_unused;
    logic [2:0]       w_top, w_best;
    logic [N_SRC-1:0] w_above, w_elig, w_claim_oh, w_eoi_oh, w_w1c, w_rise, w_pend_nxt;
    logic [5:0]       w_isr6, w_elig6;

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_top   = 3'd0;
        w_above = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (r_isr[i]) w_top = 3'(i);
        end
        w_top_any = |r_isr;
        for (int i = 0; i < N_SRC; i++) begin
            w_above[i] = !w_top_any || (3'(i) > w_top);
        end
    end

    assign w_elig  = r_pend & r_mask & w_above;
    assign w_valid = |w_elig;

    always_comb begin
        w_best = 3'd0;
        for (int i = 0; i < N_SRC; i++) begin
            if (w_elig[i]) w_best = 3'(i);
        end
    end

    // Only byte lane 0 carries register bits and commands.
    assign w_wr0   = sel && byteen[0];
    assign w_eoi   = w_wr0 && (addr == REG_CTRL) && wdata[1] && w_top_any;
    assign w_claim = w_wr0 && (addr == REG_CTRL) && wdata[0] && !wdata[1] && w_valid;
    assign w_w1c   = (w_wr0 && (addr == REG_PEND)) ? wdata[N_SRC-1:0] : '0;
    assign w_rise  = irq_in & ~r_irq_q;

    always_comb begin
        w_claim_oh = '0;
        w_eoi_oh   = '0;
        for (int i = 0; i < N_SRC; i++) begin
            w_claim_oh[i] = w_claim && (w_best == 3'(i));
            w_eoi_oh[i]   = w_eoi && (w_top == 3'(i));
        end
    end

    // Edge bits: a fresh edge beats a same-cycle clear. Level bits follow the line.
    assign w_pend_nxt = (r_mode & ((r_pend & ~(w_w1c | w_claim_oh)) | w_rise))
                      | (~r_mode & irq_in);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_irq_q <= '0;
            r_pend  <= '0;
            r_mask  <= '0;
            r_mode  <= '1;
            r_isr   <= '0;
            r_ack   <= '0;
        end else begin
            r_irq_q <= irq_in;
            r_pend  <= w_pend_nxt;
            r_isr   <= (r_isr | w_claim_oh) & ~w_eoi_oh;
            r_ack   <= w_eoi_oh;
            if (w_wr0 && (addr == REG_MASK)) r_mask <= wdata[N_SRC-1:0];
            if (w_wr0 && (addr == REG_MODE)) r_mode <= wdata[N_SRC-1:0];
        end
    end

    always_comb begin
        w_isr6  = '0;
        w_elig6 = '0;
        w_isr6[N_SRC-1:0]  = r_isr;
        w_elig6[N_SRC-1:0] = w_elig;
    end

    always_comb begin
        rdata = '0;
        if (sel) begin
            case (addr)
                REG_PEND: rdata = 32'(r_pend);
                REG_MASK: rdata = 32'(r_mask);
                REG_MODE: rdata = 32'(r_mode);
                REG_CTRL: rdata = {w_valid, 17'd0, w_isr6, 5'd0, w_best};
                default:  rdata = '0;
            endcase
        end
    end

    assign hwint    = w_elig6;
    assign irq_ack  = r_ack;
    assign w_unused = ^{wdata, byteen};

endmodule
